// File: rtl/cia_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cia_pkg : ICR bit map, limits and bus decode shared by cia_irq_ctrl  |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package cia_pkg;

  // ICR bit positions of the standard 8520 interrupt sources
  localparam int unsigned TA         = 0;
  localparam int unsigned TB         = 1;
  localparam int unsigned ALRM       = 2;
  localparam int unsigned SP         = 3;
  localparam int unsigned FLG        = 4;

  localparam int unsigned ICR_SETCLR = 7;
  localparam int unsigned NSRC_MAX   = 7;
  localparam logic [2:0]  IRQ_VEC_NONE = 3'd7;

  typedef enum logic [2:0] {
    BUS_IDLE    = 3'd0,
    BUS_ICR_RD  = 3'd1,
    BUS_MASK_WR = 3'd2,
    BUS_MODE_RD = 3'd3,
    BUS_MODE_WR = 3'd4
  } bus_op_e;

  // The ICR select wins when both selects are asserted.
  function automatic bus_op_e decode_bus(input logic wr, input logic icrs, input logic modes);
    if (icrs) begin
      return wr ? BUS_MASK_WR : BUS_ICR_RD;
    end else if (modes) begin
      return wr ? BUS_MODE_WR : BUS_MODE_RD;
    end
    return BUS_IDLE;
  endfunction

  function automatic logic [2:0] lowest_set(input logic [NSRC_MAX-1:0] v);
    logic [2:0] idx;
    idx = IRQ_VEC_NONE;
    for (int i = NSRC_MAX - 1; i >= 0; i--) begin
      if (v[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cia_irq_delay.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cia_irq_delay : DEPTH-stage shift pipeline with synchronous flush    |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module cia_irq_delay #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic flush,
  input  logic d,
  output logic q
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_ctl;
      assign unused_ctl = ^{clk, reset_n, en, flush};
      assign q = d;
    end else begin : g_pipe
      logic [DEPTH-1:0] stages_q;
      logic [DEPTH-1:0] stages_d;

      always_comb begin
        stages_d    = stages_q << 1;
        stages_d[0] = d;
        if (flush) begin
          stages_d = '0;
        end
      end

      // Reset is honoured only on enabled edges, like every other state bit.
      always_ff @(posedge clk) begin
        if (en) begin
          if (!reset_n) begin
            stages_q <= '0;
          end else begin
            stages_q <= stages_d;
          end
        end
      end

      assign q = stages_q[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/cia_irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cia_irq_ctrl : 8520-style ICR/mask pair with edge/level qualification|
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module cia_irq_ctrl
  import cia_pkg::*;
#(
  parameter int unsigned NSRC         = 5,
  parameter int unsigned IRQ_DELAY    = 1,
  parameter bit          EDGE_DEFAULT = 1'b0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            clk7_en,
  input  logic            wr,
  input  logic            icrs,
  input  logic            modes,
  input  logic [7:0]      data_in,
  input  logic [NSRC-1:0] src,
  output logic [7:0]      data_out,
  output logic            irq,
  output logic [2:0]      irq_vec
);

  logic [NSRC-1:0] icr_q,  icr_d;
  logic [NSRC-1:0] mask_q, mask_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [NSRC-1:0] src_q,  src_d;

  bus_op_e             w_op;
  logic [NSRC-1:0]     w_ev;
  logic [NSRC-1:0]     w_active;
  logic                w_pend;
  logic                w_flush;
  logic [NSRC_MAX-1:0] w_icr_ext;
  logic [NSRC_MAX-1:0] w_mode_ext;
  logic [NSRC_MAX-1:0] w_active_ext;
  logic                unused_data;

  assign w_op = decode_bus(wr, icrs, modes);

  // Edge-mode sources fire only on a 0->1 transition relative to the last enabled sample.
  assign w_ev = (mode_q & src & ~src_q) | (~mode_q & src);

  always_comb begin
    src_d  = src;
    icr_d  = icr_q | w_ev;
    mask_d = mask_q;
    mode_d = mode_q;
    case (w_op)
      BUS_ICR_RD: begin
        icr_d = w_ev;
      end
      BUS_MASK_WR: begin
        if (data_in[ICR_SETCLR]) begin
          mask_d = mask_q | data_in[NSRC-1:0];
        end else begin
          mask_d = mask_q & ~data_in[NSRC-1:0];
        end
      end
      BUS_MODE_WR: begin
        mode_d = data_in[NSRC-1:0];
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clk7_en) begin
      if (!reset_n) begin
        icr_q  <= '0;
        mask_q <= '0;
        mode_q <= {NSRC{EDGE_DEFAULT}};
        src_q  <= '0;
      end else begin
        icr_q  <= icr_d;
        mask_q <= mask_d;
        mode_q <= mode_d;
        src_q  <= src_d;
      end
    end
  end

  assign w_active = icr_q & mask_q;
  assign w_pend   = |w_active;
  assign w_flush  = (w_op == BUS_ICR_RD);

  cia_irq_delay #(
    .DEPTH (IRQ_DELAY)
  ) u_delay (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (clk7_en),
    .flush   (w_flush),
    .d       (w_pend),
    .q       (irq)
  );

  generate
    if (NSRC < NSRC_MAX) begin : g_pad
      localparam int unsigned PAD = NSRC_MAX - NSRC;
      assign w_icr_ext    = {{PAD{1'b0}}, icr_q};
      assign w_mode_ext   = {{PAD{1'b0}}, mode_q};
      assign w_active_ext = {{PAD{1'b0}}, w_active};
    end else begin : g_full
      assign w_icr_ext    = icr_q;
      assign w_mode_ext   = mode_q;
      assign w_active_ext = w_active;
    end
  endgenerate

  assign irq_vec = lowest_set(w_active_ext);

  always_comb begin
    data_out = 8'h00;
    case (w_op)
      BUS_ICR_RD:  data_out = {irq, w_icr_ext};
      BUS_MODE_RD: data_out = {1'b0, w_mode_ext};
      default: begin
      end
    endcase
  end

  // Write bits above the implemented sources carry no meaning.
  assign unused_data = ^data_in;

endmodule
`default_nettype wire

// File: tb/tb_cia_irq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_cia_irq_ctrl : table-driven scoreboard bench for cia_irq_ctrl     |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_cia_irq_ctrl;
  import cia_pkg::*;

  localparam int unsigned NSRC         = 5;
  localparam int unsigned IRQ_DELAY    = 1;
  localparam bit          EDGE_DEFAULT = 1'b0;

  localparam int OP_NOP = 0;
  localparam int OP_RD  = 1;
  localparam int OP_MW  = 2;
  localparam int OP_MR  = 3;
  localparam int OP_MDW = 4;
  localparam int OP_BW  = 5;

  localparam logic [NSRC-1:0] S_TA   = NSRC'(1) << TA;
  localparam logic [NSRC-1:0] S_TB   = NSRC'(1) << TB;
  localparam logic [NSRC-1:0] S_ALRM = NSRC'(1) << ALRM;
  localparam logic [NSRC-1:0] S_SP   = NSRC'(1) << SP;
  localparam logic [NSRC-1:0] S_FLG  = NSRC'(1) << FLG;

  // One cycle of stimulus plus the outputs required during that cycle.
  typedef struct {
    bit              en;
    bit              rn;
    int              op;
    logic [7:0]      din;
    logic [NSRC-1:0] s;
    logic [7:0]      dout;
    logic            irq;
    logic [2:0]      vec;
  } row_t;

  logic            clk;
  logic            reset_n;
  logic            clk7_en;
  logic            wr;
  logic            icrs;
  logic            modes;
  logic [7:0]      data_in;
  logic [NSRC-1:0] src;
  logic [7:0]      data_out;
  logic            irq;
  logic [2:0]      irq_vec;

  row_t sb[$];
  int   errors = 0;
  int   checks = 0;

  cia_irq_ctrl #(
    .NSRC         (NSRC),
    .IRQ_DELAY    (IRQ_DELAY),
    .EDGE_DEFAULT (EDGE_DEFAULT)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .clk7_en  (clk7_en),
    .wr       (wr),
    .icrs     (icrs),
    .modes    (modes),
    .data_in  (data_in),
    .src      (src),
    .data_out (data_out),
    .irq      (irq),
    .irq_vec  (irq_vec)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  function automatic row_t rw(bit en, bit rn, int op, logic [7:0] din, logic [NSRC-1:0] s,
                              logic [7:0] dout, logic irq_e, logic [2:0] vec);
    row_t x;
    x.en = en; x.rn = rn; x.op = op; x.din = din; x.s = s;
    x.dout = dout; x.irq = irq_e; x.vec = vec;
    return x;
  endfunction

  function automatic row_t r(int op, logic [7:0] din, logic [NSRC-1:0] s,
                             logic [7:0] dout, logic irq_e, logic [2:0] vec);
    return rw(1'b1, 1'b1, op, din, s, dout, irq_e, vec);
  endfunction

  task automatic drive_row(input row_t x);
    clk7_en = x.en;
    reset_n = x.rn;
    data_in = x.din;
    src     = x.s;
    wr      = (x.op == OP_MW) || (x.op == OP_MDW) || (x.op == OP_BW);
    icrs    = (x.op == OP_RD) || (x.op == OP_MW)  || (x.op == OP_BW);
    modes   = (x.op == OP_MR) || (x.op == OP_MDW) || (x.op == OP_BW);
    sb.push_back(x);
  endtask

  task automatic test_reset();
    row_t rows[$];
    row_t exp;
    rows.push_back(r(OP_NOP, 8'h00, '0, 8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_MR,  8'h00, '0, 8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_RD,  8'h00, '0, 8'h00, 1'b0, 3'd7));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      #2;
      exp = sb.pop_front();
      checks++;
      if (data_out !== exp.dout || irq !== exp.irq || irq_vec !== exp.vec) begin
        errors++;
        $display("FAIL reset[%0d]: got data_out=%02h irq=%b irq_vec=%0d, want data_out=%02h irq=%b irq_vec=%0d",
                 i, data_out, irq, irq_vec, exp.dout, exp.irq, exp.vec);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_basic();
    row_t rows[$];
    row_t exp;
    rows.push_back(r(OP_MW,  8'h81, '0,   8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_NOP, 8'h00, S_TA, 8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_NOP, 8'h00, '0,   8'h00, 1'b0, 3'd0));
    rows.push_back(r(OP_RD,  8'h00, '0,   8'h81, 1'b1, 3'd0));
    rows.push_back(r(OP_RD,  8'h00, '0,   8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_NOP, 8'h00, '0,   8'h00, 1'b0, 3'd7));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      #2;
      exp = sb.pop_front();
      checks++;
      if (data_out !== exp.dout || irq !== exp.irq || irq_vec !== exp.vec) begin
        errors++;
        $display("FAIL basic[%0d]: got data_out=%02h irq=%b irq_vec=%0d, want data_out=%02h irq=%b irq_vec=%0d",
                 i, data_out, irq, irq_vec, exp.dout, exp.irq, exp.vec);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_mask_late();
    row_t rows[$];
    row_t exp;
    rows.push_back(r(OP_NOP, 8'h00, S_TB, 8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_NOP, 8'h00, '0,   8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_RD,  8'h00, '0,   8'h02, 1'b0, 3'd7));
    rows.push_back(r(OP_NOP, 8'h00, S_TB, 8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_MW,  8'h82, '0,   8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_NOP, 8'h00, '0,   8'h00, 1'b0, 3'd1));
    rows.push_back(r(OP_NOP, 8'h00, '0,   8'h00, 1'b1, 3'd1));
    rows.push_back(r(OP_RD,  8'h00, '0,   8'h82, 1'b1, 3'd1));
    rows.push_back(r(OP_NOP, 8'h00, '0,   8'h00, 1'b0, 3'd7));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      #2;
      exp = sb.pop_front();
      checks++;
      if (data_out !== exp.dout || irq !== exp.irq || irq_vec !== exp.vec) begin
        errors++;
        $display("FAIL mask_late[%0d]: got data_out=%02h irq=%b irq_vec=%0d, want data_out=%02h irq=%b irq_vec=%0d",
                 i, data_out, irq, irq_vec, exp.dout, exp.irq, exp.vec);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_edge_mode();
    row_t rows[$];
    row_t exp;
    rows.push_back(r(OP_MDW, 8'h04, '0,     8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_MR,  8'h00, '0,     8'h04, 1'b0, 3'd7));
    rows.push_back(r(OP_NOP, 8'h00, S_ALRM, 8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_RD,  8'h00, S_ALRM, 8'h04, 1'b0, 3'd7));
    rows.push_back(r(OP_RD,  8'h00, S_ALRM, 8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_NOP, 8'h00, S_ALRM, 8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_RD,  8'h00, S_ALRM, 8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_NOP, 8'h00, '0,     8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_MDW, 8'h00, '0,     8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_NOP, 8'h00, S_ALRM, 8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_RD,  8'h00, S_ALRM, 8'h04, 1'b0, 3'd7));
    rows.push_back(r(OP_RD,  8'h00, S_ALRM, 8'h04, 1'b0, 3'd7));
    rows.push_back(r(OP_RD,  8'h00, '0,     8'h04, 1'b0, 3'd7));
    rows.push_back(r(OP_RD,  8'h00, '0,     8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_BW,  8'h84, '0,     8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_MR,  8'h00, '0,     8'h00, 1'b0, 3'd7));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      #2;
      exp = sb.pop_front();
      checks++;
      if (data_out !== exp.dout || irq !== exp.irq || irq_vec !== exp.vec) begin
        errors++;
        $display("FAIL edge_mode[%0d]: got data_out=%02h irq=%b irq_vec=%0d, want data_out=%02h irq=%b irq_vec=%0d",
                 i, data_out, irq, irq_vec, exp.dout, exp.irq, exp.vec);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_regs();
    row_t rows[$];
    row_t exp;
    rows.push_back(r(OP_MDW, 8'hFF, '0,   8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_MR,  8'h00, '0,   8'h1F, 1'b0, 3'd7));
    rows.push_back(r(OP_MDW, 8'h00, '0,   8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_MW,  8'h7F, '0,   8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_MR,  8'h00, '0,   8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_NOP, 8'h00, S_TA, 8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_NOP, 8'h00, '0,   8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_RD,  8'h00, '0,   8'h01, 1'b0, 3'd7));
    rows.push_back(r(OP_NOP, 8'h00, '0,   8'h00, 1'b0, 3'd7));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      #2;
      exp = sb.pop_front();
      checks++;
      if (data_out !== exp.dout || irq !== exp.irq || irq_vec !== exp.vec) begin
        errors++;
        $display("FAIL regs[%0d]: got data_out=%02h irq=%b irq_vec=%0d, want data_out=%02h irq=%b irq_vec=%0d",
                 i, data_out, irq, irq_vec, exp.dout, exp.irq, exp.vec);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_coincident();
    row_t rows[$];
    row_t exp;
    rows.push_back(r(OP_MW,  8'h88, '0,   8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_NOP, 8'h00, S_SP, 8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_NOP, 8'h00, '0,   8'h00, 1'b0, 3'd3));
    rows.push_back(r(OP_RD,  8'h00, S_SP, 8'h88, 1'b1, 3'd3));
    rows.push_back(r(OP_NOP, 8'h00, '0,   8'h00, 1'b0, 3'd3));
    rows.push_back(r(OP_NOP, 8'h00, '0,   8'h00, 1'b1, 3'd3));
    rows.push_back(r(OP_RD,  8'h00, '0,   8'h88, 1'b1, 3'd3));
    rows.push_back(r(OP_NOP, 8'h00, '0,   8'h00, 1'b0, 3'd7));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      #2;
      exp = sb.pop_front();
      checks++;
      if (data_out !== exp.dout || irq !== exp.irq || irq_vec !== exp.vec) begin
        errors++;
        $display("FAIL coincident[%0d]: got data_out=%02h irq=%b irq_vec=%0d, want data_out=%02h irq=%b irq_vec=%0d",
                 i, data_out, irq, irq_vec, exp.dout, exp.irq, exp.vec);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_priority();
    row_t rows[$];
    row_t exp;
    rows.push_back(r(OP_MW,  8'h91, '0,           8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_NOP, 8'h00, S_TA | S_FLG, 8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_NOP, 8'h00, '0,           8'h00, 1'b0, 3'd0));
    rows.push_back(r(OP_MW,  8'h01, '0,           8'h00, 1'b1, 3'd0));
    rows.push_back(r(OP_NOP, 8'h00, '0,           8'h00, 1'b1, 3'd4));
    rows.push_back(r(OP_RD,  8'h00, '0,           8'h91, 1'b1, 3'd4));
    rows.push_back(r(OP_NOP, 8'h00, '0,           8'h00, 1'b0, 3'd7));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      #2;
      exp = sb.pop_front();
      checks++;
      if (data_out !== exp.dout || irq !== exp.irq || irq_vec !== exp.vec) begin
        errors++;
        $display("FAIL priority[%0d]: got data_out=%02h irq=%b irq_vec=%0d, want data_out=%02h irq=%b irq_vec=%0d",
                 i, data_out, irq, irq_vec, exp.dout, exp.irq, exp.vec);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid();
    row_t rows[$];
    row_t exp;
    rows.push_back(r(OP_NOP, 8'h00, S_FLG, 8'h00, 1'b0, 3'd7));
    rows.push_back(rw(1'b1, 1'b0, OP_NOP, 8'h00, '0, 8'h00, 1'b0, 3'd4));
    rows.push_back(r(OP_NOP, 8'h00, '0,    8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_NOP, 8'h00, '0,    8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_NOP, 8'h00, S_FLG, 8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_NOP, 8'h00, '0,    8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_RD,  8'h00, '0,    8'h10, 1'b0, 3'd7));
    rows.push_back(r(OP_MW,  8'h90, '0,    8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_NOP, 8'h00, S_FLG, 8'h00, 1'b0, 3'd7));
    rows.push_back(r(OP_NOP, 8'h00, '0,    8'h00, 1'b0, 3'd4));
    rows.push_back(rw(1'b0, 1'b0, OP_NOP, 8'h00, '0,   8'h00, 1'b1, 3'd4));
    rows.push_back(rw(1'b0, 1'b0, OP_RD,  8'h00, '0,   8'h90, 1'b1, 3'd4));
    rows.push_back(rw(1'b0, 1'b1, OP_NOP, 8'h00, S_TA, 8'h00, 1'b1, 3'd4));
    rows.push_back(r(OP_RD,  8'h00, '0,    8'h90, 1'b1, 3'd4));
    rows.push_back(r(OP_NOP, 8'h00, '0,    8'h00, 1'b0, 3'd7));
    foreach (rows[i]) begin
      drive_row(rows[i]);
      #2;
      exp = sb.pop_front();
      checks++;
      if (data_out !== exp.dout || irq !== exp.irq || irq_vec !== exp.vec) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got data_out=%02h irq=%b irq_vec=%0d, want data_out=%02h irq=%b irq_vec=%0d",
                 i, data_out, irq, irq_vec, exp.dout, exp.irq, exp.vec);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    clk7_en = 1'b1;
    reset_n = 1'b0;
    wr      = 1'b0;
    icrs    = 1'b0;
    modes   = 1'b0;
    data_in = 8'h00;
    src     = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_mask_late();
    test_edge_mode();
    test_regs();
    test_coincident();
    test_priority();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cia_irq_ctrl.md
# cia_irq_ctrl

Parametrised CIA interrupt controller: the interrupt data/mask register pair of the 8520, generalised to NSRC sources. Adds per-source edge/level qualification and a programmable IRQ assertion delay. Sits inside each CIA instance between the timer/TOD/serial/flag event sources and the CPU-side interrupt line. All state advances only on clk7_en.

## Interface
- NSRC, 5, number of interrupt sources, 1..7; source i maps to ICR bit i
- IRQ_DELAY, 1, enabled cycles from pending to irq assertion, 0..3
- EDGE_DEFAULT, 0, reset value of every mode bit (1 = rising-edge qualified)
- clk  in  1  system clock
- reset_n  in  1  reset; one clock; reset is synchronous and active-low
- clk7_en  in  1  clock enable; no state changes when low
- wr  in  1  bus write strobe (0 = read)
- icrs  in  1  ICR data/mask register select
- modes  in  1  mode register select
- data_in  in  8  bus write data
- src  in  NSRC  raw interrupt source inputs
- data_out  out  8  bus read data, 0 when not reading a selected register
- irq  out  1  interrupt request, active high
- irq_vec  out  3  lowest-numbered masked pending source, 7 when none

## Operation
- Reset (reset_n low at an enabled edge): icr=0, mask=0, mode={NSRC{EDGE_DEFAULT}}, src_q=0, delay pipeline=0; irq=0, irq_vec=7, data_out=0.
- Event: ev[i] = mode[i] ? (src[i] & ~src_q[i]) : src[i]; src_q <= src each enabled cycle. First enabled cycle after reset: a high src in edge mode counts as an edge.
- ICR latch: icrs && !wr → icr <= ev (read clears, same-cycle events survive); otherwise icr <= icr | ev.
- Mask write (icrs && wr): data_in[7]=1 → mask |= data_in[NSRC-1:0]; 0 → mask &= ~data_in[NSRC-1:0]. Bits ≥ NSRC ignored.
- Mode write (modes && wr, icrs low): mode <= data_in[NSRC-1:0]. icrs and modes both high: icrs takes effect, mode untouched.
- pend = |(icr & mask). Pipeline of IRQ_DELAY stages shifts pend; irq = last stage (irq = pend when IRQ_DELAY=0). ICR read zeroes all pipeline stages in the same enabled edge.
- Read data (combinational): icrs && !wr → {irq, 0.., icr} (bits NSRC..6 zero); modes && !wr → {0.., mode}; else 0.
- irq_vec: priority encode of icr & mask, bit 0 highest; 7 when none.
- Mask write enabling an already-latched bit raises pend immediately; irq follows after IRQ_DELAY.

## Timing
- Source sampled at enabled edge k → icr bit visible after k; irq high after edge k+IRQ_DELAY (IRQ_DELAY=0: after k).
- ICR read at enabled edge r: icr and pipeline cleared at r; irq low after r unless IRQ_DELAY=0 and an event arrived at r.
- Register writes take effect at the enabled edge they are sampled; read data valid in the same cycle as select.
- clk7_en low: every register holds, including during reset_n low.

## Structure
- Shared package cia_pkg: ICR bit index constants (TA=0, TB=1, ALRM=2, SP=3, FLG=4), ICR_SETCLR=7, NSRC_MAX=7, IRQ_VEC_NONE=3'd7.
- One sub-module: cia_irq_delay (parametrised depth shift pipeline with synchronous flush, depth 0 = wire).

## Test plan
- Reset, mask write 0x81, pulse src[0] one enabled cycle, IRQ_DELAY=1 → icr=0x01, irq high one enabled cycle later, read returns 0x81, next read 0x00, irq low.
- src[1] pulsed, mask clear → read 0x02, irq=0; then write 0x82 → irq asserts after IRQ_DELAY, irq_vec=1.
- Mode write 0x04, hold src[2] high 5 cycles → exactly one latch; level mode same stimulus re-latches after each read.
- ICR read coincident with src[3] pulse (mask 0x88) → read shows prior icr, icr=0x08 afterwards, irq reasserts after delay.
- Sources 0 and 4 pending, both masked → irq_vec=0; clear mask bit 0 → irq_vec=4.
- reset_n low mid-pipeline with irq pending → all registers clear, irq=0, irq_vec=7; reset_n low while clk7_en low → no change.
